// File: rtl/rsa_keygen_if.sv
// Handshake and operand/result bundle for rsa_keygen_core.
//   master: drives start, p, q, e; observes busy, done, error, n, phi, d.
//   slave:  the key-generation core.
interface rsa_keygen_if #(
    parameter int unsigned PW = 8
);
    localparam int unsigned NW = 2 * PW;

    logic          start;
    logic [PW-1:0] p;
    logic [PW-1:0] q;
    logic [NW-1:0] e;
    logic          busy;
    logic          done;
    logic          error;
    logic [NW-1:0] n;
    logic [NW-1:0] phi;
    logic [NW-1:0] d;

    modport master (
        output start, p, q, e,
        input  busy, done, error, n, phi, d
    );

    modport slave (
        input  start, p, q, e,
        output busy, done, error, n, phi, d
    );
endinterface

// File: rtl/rsa_keygen_core.sv
// Sequential RSA key generation: n = p*q, phi = (p-1)*(q-1), d = e^-1 mod phi.
// The inverse comes from iterative extended Euclid; each quotient/remainder is produced by a
// restoring shift-subtract divider, one bit per cycle, MSB first.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - rsa_keygen_if slave: start/p/q/e in; busy/done/error/n/phi/d out
module rsa_keygen_core #(
    parameter int unsigned PW = 8
) (
    input  logic        clk,
    input  logic        rst,
    rsa_keygen_if.slave bus
);
    localparam int unsigned NW = 2 * PW;
    localparam int unsigned TW = NW + 2;
    localparam int unsigned CW = $clog2(NW);

    typedef enum logic [2:0] {
        StIdle, StSetup, StDiv, StUpdate, StFin, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        p_q, p_d, q_q, q_d;
    logic [NW-1:0]        e_q, e_d;
    logic [NW-1:0]        n_q, n_d, phi_q, phi_d, d_q, d_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [NW-1:0]        r0_q, r0_d, r1_q, r1_d, quo_q, quo_d, rem_q, rem_d;
    logic signed [TW-1:0] t0_q, t0_d, t1_q, t1_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Combinational helpers
    logic [PW-1:0]        pm1, qm1;
    logic [NW-1:0]        n_calc, phi_calc;
    logic [NW:0]          trial, diff;
    logic                 ge;
    logic signed [TW-1:0] prod, phi_s, t0_red;

    // p or q below 2 clamps its factor to 0 so phi becomes 0 and is flagged.
    assign pm1      = (p_q == '0) ? '0 : p_q - PW'(1);
    assign qm1      = (q_q == '0) ? '0 : q_q - PW'(1);
    assign n_calc   = {{PW{1'b0}}, p_q} * {{PW{1'b0}}, q_q};
    assign phi_calc = {{PW{1'b0}}, pm1} * {{PW{1'b0}}, qm1};

    // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder.
    assign trial = {rem_q, quo_q[NW-1]};
    assign diff  = trial - {1'b0, r1_q};
    assign ge    = (trial >= {1'b0, r1_q});

    // Truncated to TW bits; exact because |t| never exceeds phi.
    assign prod  = $signed({2'b00, quo_q}) * t1_q;
    assign phi_s = $signed({2'b00, phi_q});

    always_comb begin
        t0_red = t0_q;
        if (t0_q < 0) begin
            t0_red = t0_q + phi_s;
        end else if (t0_q >= phi_s) begin
            t0_red = t0_q - phi_s;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        e_d     = e_q;
        n_d     = n_q;
        phi_d   = phi_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    p_d     = bus.p;
                    q_d     = bus.q;
                    e_d     = bus.e;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                n_d   = n_calc;
                phi_d = phi_calc;
                if (phi_calc == '0 || e_q == '0) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    r0_d    = phi_calc;
                    r1_d    = e_q;
                    t0_d    = '0;
                    t1_d    = TW'(1);
                    quo_d   = phi_calc;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                rem_d = ge ? diff[NW-1:0] : trial[NW-1:0];
                quo_d = {quo_q[NW-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                r0_d = r1_q;
                r1_d = rem_q;
                t0_d = t1_q;
                t1_d = t0_q - prod;
                if (rem_q == '0) begin
                    state_d = StFin;
                end else begin
                    // Next division is r1 / rem.
                    quo_d   = r1_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            StFin: begin
                if (err_q || r0_q != NW'(1)) begin
                    err_d = 1'b1;
                    d_d   = '0;
                end else begin
                    d_d = t0_red[NW-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            phi_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            e_q     <= e_d;
            n_q     <= n_d;
            phi_q   <= phi_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.error = err_q;
    assign bus.n     = n_q;
    assign bus.phi   = phi_q;
    assign bus.d     = d_q;
endmodule

// File: tb/tb_rsa_keygen_core.sv
// Directed bench for rsa_keygen_core with hand-computed key vectors.
module tb_rsa_keygen_core;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rsa_keygen_if #(.PW(PW)) bus ();

    rsa_keygen_core #(.PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int p, input int q, input int e);
        @(negedge clk);
        bus.p     = p[PW-1:0];
        bus.q     = q[PW-1:0];
        bus.e     = e[2*PW-1:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic run_expect(input string tag, input int p, input int q, input int e,
                              input int exp_n, input int exp_phi, input int exp_d,
                              input int exp_err);
        pulse_start(p, q, e);
        check_eq({tag, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
        check_eq({tag, "_done_clr"}, {31'd0, bus.done}, 32'd0);
        wait_done(tag);
        check_eq({tag, "_n"}, 32'(bus.n), exp_n);
        check_eq({tag, "_phi"}, 32'(bus.phi), exp_phi);
        check_eq({tag, "_d"}, 32'(bus.d), exp_d);
        check_eq({tag, "_err"}, {31'd0, bus.error}, exp_err);
        check_eq({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, bus.error}, 32'd0);
        check_eq({tag, "_n"}, 32'(bus.n), 32'd0);
        check_eq({tag, "_phi"}, 32'(bus.phi), 32'd0);
        check_eq({tag, "_d"}, 32'(bus.d), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.p     = '0;
        bus.q     = '0;
        bus.e     = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_expect("k61_53", 61, 53, 17, 3233, 3120, 2753, 0);
        // Outputs hold while idle in DONE.
        repeat (10) @(negedge clk);
        check_eq("hold_d", 32'(bus.d), 32'd2753);
        check_eq("hold_done", {31'd0, bus.done}, 32'd1);

        run_expect("k11_13", 11, 13, 7, 143, 120, 103, 0);
        run_expect("k5_7_ebig", 5, 7, 29, 35, 24, 5, 0);
        run_expect("gcd3", 7, 13, 3, 91, 72, 0, 1);
        run_expect("phi0", 1, 13, 5, 13, 0, 0, 1);
        run_expect("e1", 11, 13, 1, 143, 120, 1, 0);
        run_expect("phi1", 2, 2, 1, 4, 1, 0, 0);

        // A start pulse during busy with different operands must be ignored.
        pulse_start(11, 13, 7);
        repeat (3) @(negedge clk);
        bus.p     = 8'd5;
        bus.q     = 8'd7;
        bus.e     = 16'd29;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore");
        check_eq("ignore_n", 32'(bus.n), 32'd143);
        check_eq("ignore_d", 32'(bus.d), 32'd103);

        // Reset in the middle of a division clears everything immediately.
        pulse_start(61, 53, 17);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_expect("after_rst", 61, 53, 17, 3233, 3120, 2753, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
